// File: rtl/opb_reg_master_arbiter.sv
// Two-requester OPB master for single-beat register access.
// Round-robin grant, OPB handshake sequencing, retry with one-cycle backoff,
// ack timeout, and one response strobe per accepted request.
// Bus outputs are registered and forced to zero outside XFER so the
// wired-OR OPB segment stays clean.
module opb_reg_master_arbiter #(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_4000,
    parameter int          C_TOUT_CYCLES = 16,
    parameter int          C_MAX_RETRY   = 3
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:1]  req_valid,
    output logic [0:1]  req_ready,
    input  logic [0:1]  req_rnw,
    input  logic [0:15] req_addr,
    input  logic [0:63] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [0:31] rsp_rdata,
    output logic        rsp_err,
    output logic [0:31] M_ABus,
    output logic [0:3]  M_BE,
    output logic [0:31] M_DBus,
    output logic        M_RNW,
    output logic        M_select,
    output logic        M_seqAddr,
    input  logic [0:31] Sl_DBus,
    input  logic        Sl_xferAck,
    input  logic        Sl_errAck,
    input  logic        Sl_retry,
    input  logic        Sl_toutSup
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_XFER    = 2'b01,
        ST_BACKOFF = 2'b10,
        ST_RESP    = 2'b11
    } state_t;

    localparam logic [7:0] TOUT_LAST = 8'(C_TOUT_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX = 8'(C_MAX_RETRY);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        rnw_q, rnw_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tout_q, tout_d;
    logic [7:0]  retry_q, retry_d;

    logic        m_select_q, m_select_d;
    logic        m_rnw_q, m_rnw_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] m_abus_q, m_abus_d;
    logic [31:0] m_dbus_q, m_dbus_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        gnt_valid_s;
    logic        gnt_id_s;
    logic        unused_addr_bits_s;

    // Byte-lane bits of each offset are dropped: accesses are word aligned.
    assign unused_addr_bits_s = ^{req_addr[6:7], req_addr[14:15]};

    // Round-robin grant in IDLE; on a tie the requester that lost last time wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        req_ready   = 2'b00;
        if (OPB_Rst_n && (state_q == ST_IDLE)) begin
            gnt_valid_s = req_valid[0] | req_valid[1];
            if (req_valid[0] && req_valid[1]) begin
                gnt_id_s = ~last_q;
            end else begin
                gnt_id_s = req_valid[1];
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
        req_ready[0] = gnt_valid_s & ~gnt_id_s;
        req_ready[1] = gnt_valid_s & gnt_id_s;
    end

    // Next-state, request capture, counters and response generation.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tout_d      = tout_q;
        retry_d     = retry_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_XFER;
                    last_d  = gnt_id_s;
                    owner_d = gnt_id_s;
                    if (gnt_id_s) begin
                        rnw_d   = req_rnw[1];
                        addr_d  = req_addr[8:13];
                        wdata_d = req_wdata[32:63];
                    end else begin
                        rnw_d   = req_rnw[0];
                        addr_d  = req_addr[0:5];
                        wdata_d = req_wdata[0:31];
                    end
                    tout_d  = 8'h00;
                    retry_d = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (Sl_xferAck) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_err_d   = Sl_errAck;
                    if (rnw_q && !Sl_errAck) begin
                        rsp_rdata_d = Sl_DBus;
                    end else begin
                        rsp_rdata_d = 32'h0000_0000;
                    end
                end else if (Sl_retry) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = owner_q;
                        rsp_err_d   = 1'b1;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_BACKOFF;
                    end
                end else if (Sl_toutSup) begin
                    tout_d = tout_q;
                end else if (tout_q == TOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    tout_d = tout_q + 8'd1;
                end
            end
            ST_BACKOFF: begin
                tout_d  = 8'h00;
                state_d = ST_XFER;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus drive for the coming cycle: only XFER puts anything on the OR-bus.
    always_comb begin
        m_select_d = 1'b0;
        m_rnw_d    = 1'b0;
        m_be_d     = 4'h0;
        m_abus_d   = 32'h0000_0000;
        m_dbus_d   = 32'h0000_0000;
        if (state_d == ST_XFER) begin
            m_select_d = 1'b1;
            m_rnw_d    = rnw_d;
            m_be_d     = 4'hF;
            m_abus_d   = C_BASEADDR | {24'h00_0000, addr_d, 2'b00};
            if (rnw_d) begin
                m_dbus_d = 32'h0000_0000;
            end else begin
                m_dbus_d = wdata_d;
            end
        end else begin
            m_select_d = 1'b0;
        end
    end

    // State, context and output registers with synchronous active-low reset.
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 32'h0000_0000;
            tout_q      <= 8'h00;
            retry_q     <= 8'h00;
            m_select_q  <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_be_q      <= 4'h0;
            m_abus_q    <= 32'h0000_0000;
            m_dbus_q    <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tout_q      <= tout_d;
            retry_q     <= retry_d;
            m_select_q  <= m_select_d;
            m_rnw_q     <= m_rnw_d;
            m_be_q      <= m_be_d;
            m_abus_q    <= m_abus_d;
            m_dbus_q    <= m_dbus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign M_select  = m_select_q;
    assign M_RNW     = m_rnw_q;
    assign M_BE      = m_be_q;
    assign M_ABus    = m_abus_q;
    assign M_DBus    = m_dbus_q;
    assign M_seqAddr = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/opb_reg_master_arbiter.md
# opb_reg_master_arbiter

Two-requester OPB master that shares one OPB bus segment between requesters and runs single-beat register reads and writes to the software-register slaves in the 256-byte window at C_BASEADDR, such as the mixer count register. It sits on the OPB side next to the register slaves. Requester 0 is typically the power-up init sequencer; requester 1 is the host/debug path. The block arbitrates round-robin, sequences the OPB handshake, retries on Sl_retry, times out on silence and returns one response per accepted request.

## Interface
- C_BASEADDR, 32'h01004000, base of the register window; ORed with the request offset
- C_TOUT_CYCLES, 16, cycles without ack before timeout (range 2..255)
- C_MAX_RETRY, 3, Sl_retry events tolerated per request; the next one is an error
- OPB_Clk  in  1  bus clock; all logic on rising edge
- OPB_Rst_n  in  1  synchronous, active-low reset
- req_valid  in  [0:1]  request pending, per requester (bit 0 = requester 0)
- req_ready  out  [0:1]  one-cycle accept pulse, one-hot
- req_rnw  in  [0:1]  1 = read, 0 = write
- req_addr  in  [0:15]  byte offsets; [0:7] requester 0, [8:15] requester 1; bits 6..7 of each byte ignored (word aligned)
- req_wdata  in  [0:63]  write data; [0:31] requester 0, [32:63] requester 1
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester that owns the response
- rsp_rdata  out  [0:31]  read data (0 for writes and errors)
- rsp_err  out  1  errAck, timeout or retry exhaustion
- M_ABus  out  [0:31]; M_BE  out  [0:3]; M_DBus  out  [0:31]; M_RNW  out  1; M_select  out  1; M_seqAddr  out  1  OPB master outputs
- Sl_DBus  in  [0:31]; Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup  in  1 each  ORed slave returns

## Operation
- States: IDLE, XFER, BACKOFF, RESP.
- **IDLE:** if any req_valid bit is set, grant a requester and pulse its req_ready for that cycle.
  - Capture rnw, addr and wdata for the granted requester.
  - Clear the timeout and retry counters, then go to XFER.
- **Arbitration:** round-robin on a last-grant pointer. The pointer resets to 1, so requester 0 wins the first conflict. When both requesters are valid, grants alternate.
- **XFER:** drive the bus as follows.
  - M_select = 1.
  - M_ABus = C_BASEADDR | {24'b0, addr[0:5], 2'b00}.
  - M_BE = 4'b1111 and M_seqAddr = 0.
  - M_RNW = rnw.
  - M_DBus = wdata for writes, 0 for reads.
- **XFER exits, in priority order when several occur in the same cycle:**
  1. Sl_xferAck: latch Sl_DBus if this is a read; rsp_err = Sl_errAck; go to RESP.
  2. Sl_retry: if the retry count is C_MAX_RETRY, go to RESP with err = 1; otherwise increment the count and go to BACKOFF.
  3. Timeout counter reaches C_TOUT_CYCLES-1: go to RESP with err = 1.
- **Timeout counter:** increments each XFER cycle and holds while Sl_toutSup = 1.
- **BACKOFF:** exactly one cycle with all M_* outputs at 0. Clear the timeout counter and return to XFER.
- **RESP:** rsp_valid = 1 for one cycle; rsp_id = owner; rsp_rdata = latched data, or 0 for writes and errors. Return to IDLE.
- **Bus hygiene:** all M_* outputs are 0 whenever the block is not in XFER (OR-bus requirement).
- **Reset:** every output is 0. State = IDLE, pointer = 1, counters = 0.
- **Reset mid-transaction:** the transaction is abandoned with no rsp_valid. The bus is released on the next edge.
- **Request rules:** requesters hold their request stable until they see req_ready. req_valid dropping before grant is legal.

## Timing
- Grant: req_ready is high in the cycle req_valid is seen in IDLE (combinational on req_valid, registered state).
- M_select rises on the cycle after grant.
- For an ack arriving k cycles after M_select rises (k ≥ 0), rsp_valid is asserted k+1 cycles after M_select rises. Minimum request-to-response latency is 2 cycles.
- A new grant is possible on the cycle after RESP, so the peak rate is one transaction per 3 cycles plus slave wait time.
- Timeout: with no ack and Sl_toutSup = 0, rsp_valid with err = 1 occurs C_TOUT_CYCLES cycles after M_select rises.

## Test plan
- **Write:** requester 0 writes 0xDEADBEEF to offset 0x00; slave acks 2 cycles after select. Expect:
  - M_ABus = 0x01004000, M_RNW = 0, M_DBus = 0xDEADBEEF.
  - rsp_valid with id 0, err 0, rdata 0.
- **Read:** requester 1 reads offset 0x04; slave returns 0x12345678 with xferAck. Expect:
  - M_ABus = 0x01004004.
  - rsp id 1, rdata 0x12345678, err 0.
- **Contention:** both requesters valid continuously for 4 transactions. Expect grants 0, 1, 0, 1 and M_* = 0 in every IDLE/RESP cycle.
- **Retry:** slave asserts Sl_retry twice, then xferAck. Expect:
  - Two 1-cycle select gaps.
  - err 0.
  - With 4 retries (exceeding C_MAX_RETRY = 3): rsp_err 1 after the 4th retry.
- **Timeout:** no ack with Sl_toutSup = 0. Expect rsp_err 1 at 16 cycles after select. With Sl_toutSup held high for 10 cycles, the error arrives at 26 cycles.
- **Abort:** OPB_Rst_n low for 1 cycle during XFER. Expect:
  - All outputs 0 on the next edge and no rsp_valid.
  - The next request is granted to requester 0.
